seg7_scan_driver: RTL

//  Output-side counterpart of the board I/O path: time-multiplexes NUM_DIGITS hex digits onto one shared,

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_scan_driver_hex.sv | 11 +
 rtl/seg7_scan_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex glyph table,
// the all-off pattern and the two-state scan FSM encoding.
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with a double-buffered frame and inter-digit blanking.
// Optional SEG7_BRIGHTNESS_EN adds a 3-bit PWM brightness input gating the anodes.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [2:0]              bright,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done,
  output logic                    load_pending
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [NUM_DIGITS-1:0][3:0] act_data_reg, sh_data_reg;
  logic [NUM_DIGITS-1:0]      act_dp_reg, sh_dp_reg;
  logic [NUM_DIGITS-1:0]      act_blank_reg, sh_blank_reg;
  logic                       load_pending_reg;

  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_n_reg, dp_n_next;
  logic                  frame_boundary;
  logic                  bright_ok;

  logic [6:0] digit_seg [NUM_DIGITS];

  // Last cycle of the final digit's slot: the only point where the active frame may change.
  assign frame_boundary = (state_reg == ST_ON) && (cnt_reg == CNT_SLOT_END) &&
                          (idx_reg == IDX_LAST);

  // Scan sequencing: cnt runs across the whole slot, BLANK covers its first BLANK_CYCLES.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    if (state_reg == ST_BLANK) begin
      if (cnt_reg == CNT_BLANK_END) begin
        state_next = ST_ON;
      end
    end else if (cnt_reg == CNT_SLOT_END) begin
      state_next = ST_BLANK;
      cnt_next   = '0;
      idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Shadow/active double buffer; a load coinciding with the boundary bypasses the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data_reg      <= '0;
      sh_dp_reg        <= '0;
      sh_blank_reg     <= '1;
      act_data_reg     <= '0;
      act_dp_reg       <= '0;
      act_blank_reg    <= '1;
      load_pending_reg <= 1'b0;
    end else if (load) begin
      sh_data_reg  <= data_in;
      sh_dp_reg    <= dp_in;
      sh_blank_reg <= blank_in;
      if (frame_boundary) begin
        act_data_reg     <= data_in;
        act_dp_reg       <= dp_in;
        act_blank_reg    <= blank_in;
        load_pending_reg <= 1'b0;
      end else begin
        load_pending_reg <= 1'b1;
      end
    end else if (frame_boundary && load_pending_reg) begin
      act_data_reg     <= sh_data_reg;
      act_dp_reg       <= sh_dp_reg;
      act_blank_reg    <= sh_blank_reg;
      load_pending_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    hex_to_seg7 u_hex_to_seg7 (
      .nibble (act_data_reg[gi]),
      .seg    (digit_seg[gi])
    );
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0] pwm_reg, pwm_next;

  assign pwm_next  = pwm_reg + 3'd1;
  // Compare against the PWM value that will be current when the anode register updates.
  assign bright_ok = (pwm_next <= bright);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_reg <= '0;
    end else begin
      pwm_reg <= pwm_next;
    end
  end
`else
  assign bright_ok = 1'b1;
`endif

  // Outputs are computed from the next scan position so they change on the same edge as the FSM.
  always_comb begin
    an_next   = '1;
    seg_next  = SEG_OFF;
    dp_n_next = 1'b1;
    if ((state_next == ST_ON) && !act_blank_reg[idx_next]) begin
      seg_next  = digit_seg[idx_next];
      dp_n_next = ~act_dp_reg[idx_next];
      if (bright_ok) begin
        an_next[idx_next] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg   <= '1;
      seg_reg  <= SEG_OFF;
      dp_n_reg <= 1'b1;
    end else begin
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      dp_n_reg <= dp_n_next;
    end
  end

  assign an           = an_reg;
  assign seg          = seg_reg;
  assign dp_n         = dp_n_reg;
  assign frame_done   = frame_boundary;
  assign load_pending = load_pending_reg;

endmodule
